uart_rx_fifo: RTL and testbench

Buffered UART receiver: it is the receive-side counterpart of the buffered UART transmitter. It recovers 8-N-1 serial frames (1 start bit, 8 data bits LSB first, no parity, 1 stop bit) from `rxPin` and queues the bytes in an internal FIFO for the host logic. It flags framing errors and FIFO overflow. It sits between the board RX pin and the command/packet parser.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx.sv | 97 +++++++++
 rtl/uart_rx_fifo.sv | 80 ++++++++
 tb/tb_uart_rx_fifo.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud divider helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    function automatic int bit_ticks(input int clock, input int baud);
        return clock / baud;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8-N-1 receiver: input synchronizer, bit timer, frame FSM and shift register.
import uart_pkg::*;

module uart_rx #(
    parameter int CLOCK = 50000000,
    parameter int BAUD  = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxPin,
    output logic [7:0] rxData,
    output logic       rxValid,
    output logic       frameErr,
    output logic       busy,
    output logic [6:0] debug
);

    localparam int BIT_TICKS = bit_ticks(CLOCK, BAUD);
    localparam int HALF      = BIT_TICKS / 2;
    localparam int TW        = $clog2(BIT_TICKS + 1);
    localparam logic [TW-1:0] BIT_END  = TW'(BIT_TICKS - 1);
    localparam logic [TW-1:0] HALF_END = TW'(HALF - 1);

    rx_state_t     state, nxt;
    logic          s1, rxSync;
    logic [TW-1:0] tick;
    logic [2:0]    bitIdx;
    logic [7:0]    sr;
    logic          bitEnd, halfEnd;

    assign bitEnd  = (tick == BIT_END);
    assign halfEnd = (tick == HALF_END);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1     <= 1'b1;
            rxSync <= 1'b1;
        end else begin
            s1     <= rxPin;
            rxSync <= s1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:  if (!rxSync) nxt = START;
            START: if (halfEnd) nxt = rxSync ? IDLE : DATA;
            DATA:  if (bitEnd && bitIdx == 3'd7) nxt = STOP;
            STOP:  if (bitEnd) nxt = rxSync ? IDLE : BREAK;
            BREAK: if (rxSync) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Timer restarts on every state change so each state measures from its entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick   <= '0;
            bitIdx <= '0;
            sr     <= '0;
        end else begin
            if (nxt != state || state == IDLE || state == BREAK || bitEnd)
                tick <= '0;
            else
                tick <= tick + 1'b1;
            if (state == START)
                bitIdx <= '0;
            if (state == DATA && bitEnd) begin
                sr     <= {rxSync, sr[7:1]};
                bitIdx <= bitIdx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxValid  <= 1'b0;
            frameErr <= 1'b0;
        end else begin
            rxValid  <= (state == STOP) && bitEnd && rxSync;
            frameErr <= (state == STOP) && bitEnd && !rxSync;
        end
    end

    always_comb begin
        rxData = sr;
        busy   = (state != IDLE);
        debug  = {bitIdx, rxSync, state};
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Buffered UART receiver: uart_rx front end feeding a first-word-fall-through FIFO.
import uart_pkg::*;

module uart_rx_fifo #(
    parameter int BAUD  = 115200,
    parameter int CLOCK = 50000000,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rxPin,
    input  logic                     rdEn,
    output logic [7:0]               dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     frameErr,
    output logic                     overflow,
    output logic                     busy,
    output logic [7:0]               debug
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [7:0]    rxData;
    logic          rxValid;
    logic [6:0]    rxDebug;
    logic          pop, wr;

    uart_rx #(
        .CLOCK (CLOCK),
        .BAUD  (BAUD)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rxPin    (rxPin),
        .rxData   (rxData),
        .rxValid  (rxValid),
        .frameErr (frameErr),
        .busy     (busy),
        .debug    (rxDebug)
    );

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign pop   = rdEn && !empty;
    // A pop in the same cycle frees the slot the incoming byte needs.
    assign wr    = rxValid && (!full || pop);
    assign dout  = empty ? 8'h00 : mem[rp];
    assign debug = {overflow, rxDebug};

    always_ff @(posedge clk) begin
        if (wr) mem[wp] <= rxData;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr)  wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            unique case ({wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (pop)
                overflow <= 1'b0;
            else if (rxValid && full)
                overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo at 16 clocks per bit with a 4-byte FIFO.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxPin = 1'b1;
    logic       rdEn = 1'b0;
    logic [7:0] dout;
    logic       empty, full;
    logic [2:0] count;
    logic       frameErr, overflow, busy;
    logic [7:0] debug;

    int nvec = 0;
    int nerr = 0;
    logic [7:0] q[$];

    uart_rx_fifo #(
        .BAUD  (100000),
        .CLOCK (1600000),
        .DEPTH (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rxPin    (rxPin),
        .rdEn     (rdEn),
        .dout     (dout),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .frameErr (frameErr),
        .overflow (overflow),
        .busy     (busy),
        .debug    (debug)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        rxPin = 1'b1;
        rdEn = 1'b0;
        q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Drives one frame; lowtail>0 holds the line low that long from the stop bit on.
    task automatic frame(input logic [7:0] d, input int lowtail, input int popcyc,
                         output int pushcyc, output int ferrs);
        int n;
        logic [2:0] cnt0;
        logic [7:0] e;
        n = 144 + ((lowtail == 0) ? 16 : lowtail) + 4;
        pushcyc = -1;
        ferrs = 0;
        cnt0 = count;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (c < 16)                 rxPin = 1'b0;
            else if (c < 144)           rxPin = d[(c - 16) / 16];
            else if (c < 144 + lowtail) rxPin = 1'b0;
            else                        rxPin = 1'b1;
            rdEn = (c == popcyc);
            if (c == popcyc) begin
                nvec++;
                if (q.size() == 0) begin
                    nerr++;
                    $display("FAIL frame_pop: dout=%h but scoreboard empty", dout);
                end else begin
                    e = q.pop_front();
                    if (dout !== e) begin
                        nerr++;
                        $display("FAIL frame_pop: dout=%h want %h", dout, e);
                    end
                end
            end
            @(posedge clk);
            #1;
            if (frameErr) ferrs++;
            if (pushcyc < 0 && count != cnt0) pushcyc = c;
        end
        rdEn = 1'b0;
    endtask

    task automatic pop_byte(input string nm);
        logic [7:0] e;
        @(negedge clk);
        nvec++;
        if (q.size() == 0) begin
            nerr++;
            $display("FAIL %s: dout=%h but scoreboard empty", nm, dout);
        end else begin
            e = q.pop_front();
            if (dout !== e) begin
                nerr++;
                $display("FAIL %s: dout=%h want %h", nm, dout, e);
            end
        end
        rdEn = 1'b1;
        @(negedge clk);
        rdEn = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        nvec++;
        if ({empty, full, dout, count, frameErr, overflow, busy, debug}
            !== {1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 8'h08}) begin
            nerr++;
            $display("FAIL reset: e=%b f=%b d=%h c=%0d fe=%b ov=%b b=%b dbg=%h",
                     empty, full, dout, count, frameErr, overflow, busy, debug);
        end
        do_reset();
    endtask

    task automatic test_single();
        int pc, fe;
        do_reset();
        q.push_back(8'hA5);
        frame(8'hA5, 0, -1, pc, fe);
        nvec++;
        if (pc < 153 || pc > 155) begin
            nerr++;
            $display("FAIL single_latency: push at %0d want 154+-1", pc);
        end
        nvec++;
        if ({empty, dout, count} !== {1'b0, 8'hA5, 3'd1}) begin
            nerr++;
            $display("FAIL single_state: e=%b d=%h c=%0d want 0 a5 1", empty, dout, count);
        end
        pop_byte("single_pop");
        #1;
        nvec++;
        if ({empty, dout} !== {1'b1, 8'h00}) begin
            nerr++;
            $display("FAIL single_drain: e=%b d=%h want 1 00", empty, dout);
        end
    endtask

    task automatic test_glitch();
        bit seen = 0;
        int fe = 0;
        do_reset();
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            rxPin = (c >= 4);
            @(posedge clk);
            #1;
            if (busy) seen = 1;
            if (frameErr) fe++;
            if (c == 12) begin
                nvec++;
                if (busy !== 1'b0) begin
                    nerr++;
                    $display("FAIL glitch_busy_clear: busy=%b want 0", busy);
                end
            end
        end
        nvec++;
        if ({seen, count, fe[3:0]} !== {1'b1, 3'd0, 4'd0}) begin
            nerr++;
            $display("FAIL glitch: busy_seen=%b count=%0d ferr=%0d want 1 0 0", seen, count, fe);
        end
    endtask

    task automatic test_frame_err();
        int pc, fe;
        do_reset();
        frame(8'h3C, 48, -1, pc, fe);
        nvec++;
        if (fe !== 1 || count !== 3'd0) begin
            nerr++;
            $display("FAIL frame_err: pulses=%0d count=%0d want 1 0", fe, count);
        end
        q.push_back(8'h81);
        frame(8'h81, 0, -1, pc, fe);
        nvec++;
        if (fe !== 0 || count !== 3'd1) begin
            nerr++;
            $display("FAIL after_break: pulses=%0d count=%0d want 0 1", fe, count);
        end
        pop_byte("after_break_pop");
    endtask

    task automatic test_overflow();
        int pc, fe;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            q.push_back(8'(i));
            frame(8'(i), 0, -1, pc, fe);
        end
        nvec++;
        if ({full, count, overflow} !== {1'b1, 3'd4, 1'b0}) begin
            nerr++;
            $display("FAIL fill: full=%b count=%0d ov=%b want 1 4 0", full, count, overflow);
        end
        frame(8'h05, 0, -1, pc, fe);
        nvec++;
        if ({full, count, overflow} !== {1'b1, 3'd4, 1'b1}) begin
            nerr++;
            $display("FAIL overflow: full=%b count=%0d ov=%b want 1 4 1", full, count, overflow);
        end
        pop_byte("ovf_pop1");
        #1;
        nvec++;
        if ({overflow, full, count} !== {1'b0, 1'b0, 3'd3}) begin
            nerr++;
            $display("FAIL ovf_clear: ov=%b full=%b count=%0d want 0 0 3", overflow, full, count);
        end
        for (int i = 0; i < 3; i++) pop_byte("ovf_drain");
        #1;
        nvec++;
        if (empty !== 1'b1) begin
            nerr++;
            $display("FAIL ovf_empty: empty=%b want 1", empty);
        end
    endtask

    task automatic test_back_to_back();
        int pc, fe;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            q.push_back(8'(i));
            frame(8'(i), 0, -1, pc, fe);
        end
        frame(8'h06, 0, 155, pc, fe);
        q.push_back(8'h06);
        nvec++;
        if ({count, overflow, full} !== {3'd4, 1'b0, 1'b1}) begin
            nerr++;
            $display("FAIL push_pop_full: count=%0d ov=%b full=%b want 4 0 1", count, overflow, full);
        end
        for (int i = 0; i < 4; i++) pop_byte("b2b_drain");
        #1;
        nvec++;
        if (empty !== 1'b1 || q.size() != 0) begin
            nerr++;
            $display("FAIL b2b_empty: empty=%b left=%0d want 1 0", empty, q.size());
        end
    endtask

    task automatic test_reset_mid();
        int pc, fe;
        do_reset();
        q.push_back(8'h11);
        frame(8'h11, 0, -1, pc, fe);
        for (int c = 0; c < 72; c++) begin
            @(negedge clk);
            rxPin = (c >= 16);
        end
        #1;
        nvec++;
        if (busy !== 1'b1) begin
            nerr++;
            $display("FAIL mid_busy: busy=%b want 1", busy);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        nvec++;
        if ({empty, full, dout, count, frameErr, overflow, busy}
            !== {1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0}) begin
            nerr++;
            $display("FAIL mid_reset: e=%b f=%b d=%h c=%0d fe=%b ov=%b b=%b",
                     empty, full, dout, count, frameErr, overflow, busy);
        end
        q.delete();
        rxPin = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        q.push_back(8'h55);
        frame(8'h55, 0, -1, pc, fe);
        nvec++;
        if (count !== 3'd1) begin
            nerr++;
            $display("FAIL mid_recover: count=%0d want 1", count);
        end
        pop_byte("mid_recover_pop");
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
